// File: rtl/fetch_unit_if.sv
// Fetch stage bus: control-unit strobes, instruction-memory handshake and
// the decoder-facing outputs, bundled for the fetch_unit port list.
interface fetch_unit_if;
  logic        ld_pc;
  logic        cu_branch;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [15:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_read;
  logic        fetch_stall;
  logic        fetch_fault;

  // master: the fetch unit itself
  modport master (
    input  ld_pc, cu_branch, branch_target, imem_rdata, imem_ack,
    output imem_req, imem_addr, instr, instr_valid, pc, pc_read,
           fetch_stall, fetch_fault
  );

  // slave: control unit, instruction memory and decoder side
  modport slave (
    output ld_pc, cu_branch, branch_target, imem_rdata, imem_ack,
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_read,
           fetch_stall, fetch_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches 32-bit words over req/ack,
// buffers one word and presents the selected Thumb halfword to the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam logic [1:0] ST_VALID = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  // Fault is declared on the edge that ends the MAX_WAIT-th unacked cycle
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

  logic [1:0]  state_reg,      state_next;
  logic [31:0] pc_reg,         pc_next;
  logic        first_flag_reg, first_flag_next;
  logic [31:0] buf_reg,        buf_next;
  logic [29:0] tag_reg,        tag_next;
  logic        buf_valid_reg,  buf_valid_next;
  logic [15:0] instr_reg,      instr_next;
  logic [29:0] req_word_reg,   req_word_next;
  logic [7:0]  wait_cnt_reg,   wait_cnt_next;

  logic [31:0] target_pc;
  logic [29:0] eff_word;
  logic        eff_half;
  logic [15:0] buf_half   [2];
  logic [15:0] rdata_half [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign buf_half[gi]   = buf_reg[16*gi +: 16];
      assign rdata_half[gi] = bus.imem_rdata[16*gi +: 16];
    end
  endgenerate

  // PC that ld_pc would commit; the first ld_pc after reset keeps RESET_PC
  always_comb begin
    if (first_flag_reg) begin
      target_pc = pc_reg;
    end else if (bus.cu_branch) begin
      target_pc = bus.branch_target & 32'hFFFF_FFFE;
    end else begin
      target_pc = pc_reg + 32'd2;
    end
  end

  // PC that the decoder will see after this edge
  assign eff_word = bus.ld_pc ? target_pc[31:2] : pc_reg[31:2];
  assign eff_half = bus.ld_pc ? target_pc[1]    : pc_reg[1];

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    first_flag_next = first_flag_reg;
    buf_next        = buf_reg;
    tag_next        = tag_reg;
    buf_valid_next  = buf_valid_reg;
    instr_next      = instr_reg;
    req_word_next   = req_word_reg;
    wait_cnt_next   = wait_cnt_reg;

    if (bus.ld_pc) begin
      pc_next         = target_pc;
      first_flag_next = 1'b0;
    end

    case (state_reg)
      ST_VALID: begin
        if (bus.ld_pc) begin
          if (buf_valid_reg && (target_pc[31:2] == tag_reg)) begin
            instr_next = buf_half[target_pc[1]];
          end else begin
            state_next    = ST_REQ;
            req_word_next = target_pc[31:2];
            wait_cnt_next = 8'd0;
          end
        end
      end

      ST_REQ: begin
        if (bus.imem_ack) begin
          // The in-flight word is always captured, even if the PC moved away
          buf_next       = bus.imem_rdata;
          tag_next       = req_word_reg;
          buf_valid_next = 1'b1;
          if (eff_word == req_word_reg) begin
            state_next = ST_VALID;
            instr_next = rdata_half[eff_half];
          end else begin
            req_word_next = eff_word;
            wait_cnt_next = 8'd0;
          end
        end else if (wait_cnt_reg == WAIT_LIMIT) begin
          state_next     = ST_FAULT;
          buf_valid_next = 1'b0;
          wait_cnt_next  = wait_cnt_reg + 8'd1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end

      ST_FAULT: begin
        if (bus.ld_pc) begin
          state_next    = ST_REQ;
          req_word_next = target_pc[31:2];
          wait_cnt_next = 8'd0;
        end
      end

      default: begin
        state_next     = ST_FAULT;
        buf_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_REQ;
      pc_reg         <= {RESET_PC[31:1], 1'b0};
      first_flag_reg <= 1'b1;
      buf_reg        <= 32'd0;
      tag_reg        <= 30'd0;
      buf_valid_reg  <= 1'b0;
      instr_reg      <= 16'd0;
      req_word_reg   <= RESET_PC[31:2];
      wait_cnt_reg   <= 8'd0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      first_flag_reg <= first_flag_next;
      buf_reg        <= buf_next;
      tag_reg        <= tag_next;
      buf_valid_reg  <= buf_valid_next;
      instr_reg      <= instr_next;
      req_word_reg   <= req_word_next;
      wait_cnt_reg   <= wait_cnt_next;
    end
  end

  assign bus.imem_req    = (state_reg == ST_REQ);
  assign bus.imem_addr   = {req_word_reg, 2'b00};
  assign bus.instr       = instr_reg;
  assign bus.instr_valid = (state_reg == ST_VALID);
  assign bus.pc          = pc_reg;
  assign bus.pc_read     = pc_reg + 32'd4;
  assign bus.fetch_stall = (state_reg == ST_REQ);
  assign bus.fetch_fault = (state_reg == ST_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, hit/miss paths, branches, timeout
// fault, in-flight redirection and ack coinciding with ld_pc.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  fetch_unit_if bif ();

  fetch_unit #(.RESET_PC(32'h0000_0100), .MAX_WAIT(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_with(input logic [31:0] data);
    bif.imem_ack   = 1'b1;
    bif.imem_rdata = data;
    step();
    bif.imem_ack   = 1'b0;
    bif.imem_rdata = 32'd0;
  endtask

  task automatic do_ld(input logic br, input logic [31:0] tgt);
    bif.ld_pc         = 1'b1;
    bif.cu_branch     = br;
    bif.branch_target = tgt;
    step();
    bif.ld_pc         = 1'b0;
    bif.cu_branch     = 1'b0;
    bif.branch_target = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if (bif.imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b expected 1", bif.imem_req); end
    checks++; if (bif.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bif.instr_valid); end
    checks++; if (bif.instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h expected 0000", bif.instr); end
    checks++; if (bif.fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", bif.fetch_fault); end
    checks++; if (bif.pc !== 32'h0000_0100) begin errors++; $display("FAIL reset_pc: got %h expected 00000100", bif.pc); end
    checks++; if (bif.imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL reset_addr: got %h expected 00000100", bif.imem_addr); end
    rst = 1'b0;
    $display("reset: pc=%h req=%b", bif.pc, bif.imem_req);
  endtask

  task automatic test_first_fetch();
    step();
    checks++; if (bif.imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL first_addr: got %h expected 00000100", bif.imem_addr); end
    ack_with(32'hBBBB_AAAA);
    checks++; if (bif.instr !== 16'hAAAA) begin errors++; $display("FAIL first_instr: got %h expected aaaa", bif.instr); end
    checks++; if (bif.instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", bif.instr_valid); end
    checks++; if (bif.pc_read !== 32'h0000_0104) begin errors++; $display("FAIL first_pc_read: got %h expected 00000104", bif.pc_read); end
    checks++; if (bif.imem_req !== 1'b0) begin errors++; $display("FAIL first_req_drop: got %b expected 0", bif.imem_req); end
    $display("first fetch: pc=%h instr=%h", bif.pc, bif.instr);
  endtask

  task automatic test_hit();
    // first ld_pc after reset keeps the PC, even with a branch request
    do_ld(1'b1, 32'h0000_0700);
    checks++; if (bif.pc !== 32'h0000_0100) begin errors++; $display("FAIL firstflag_pc: got %h expected 00000100", bif.pc); end
    checks++; if (bif.instr !== 16'hAAAA) begin errors++; $display("FAIL firstflag_instr: got %h expected aaaa", bif.instr); end
    do_ld(1'b0, 32'd0);
    checks++; if (bif.pc !== 32'h0000_0102) begin errors++; $display("FAIL hit_pc: got %h expected 00000102", bif.pc); end
    checks++; if (bif.instr !== 16'hBBBB) begin errors++; $display("FAIL hit_instr: got %h expected bbbb", bif.instr); end
    checks++; if (bif.instr_valid !== 1'b1) begin errors++; $display("FAIL hit_valid: got %b expected 1", bif.instr_valid); end
    checks++; if (bif.imem_req !== 1'b0) begin errors++; $display("FAIL hit_noreq: got %b expected 0", bif.imem_req); end
    $display("hit: pc=%h instr=%h", bif.pc, bif.instr);
  endtask

  task automatic test_miss();
    do_ld(1'b0, 32'd0);
    checks++; if (bif.instr_valid !== 1'b0) begin errors++; $display("FAIL miss_valid: got %b expected 0", bif.instr_valid); end
    checks++; if (bif.imem_addr !== 32'h0000_0104) begin errors++; $display("FAIL miss_addr: got %h expected 00000104", bif.imem_addr); end
    checks++; if (bif.fetch_stall !== 1'b1) begin errors++; $display("FAIL miss_stall: got %b expected 1", bif.fetch_stall); end
    ack_with(32'h2222_1111);
    checks++; if (bif.instr !== 16'h1111) begin errors++; $display("FAIL miss_instr: got %h expected 1111", bif.instr); end
    checks++; if (bif.instr_valid !== 1'b1) begin errors++; $display("FAIL miss_valid2: got %b expected 1", bif.instr_valid); end
    $display("miss: pc=%h instr=%h", bif.pc, bif.instr);
  endtask

  task automatic test_branch();
    // cu_branch without ld_pc must not move the PC
    bif.cu_branch = 1'b1; bif.branch_target = 32'h0000_0700;
    step();
    bif.cu_branch = 1'b0;
    checks++; if (bif.pc !== 32'h0000_0104) begin errors++; $display("FAIL branch_noload_pc: got %h expected 00000104", bif.pc); end
    do_ld(1'b1, 32'h0000_0207);
    checks++; if (bif.pc !== 32'h0000_0206) begin errors++; $display("FAIL branch_pc: got %h expected 00000206", bif.pc); end
    checks++; if (bif.imem_addr !== 32'h0000_0204) begin errors++; $display("FAIL branch_addr: got %h expected 00000204", bif.imem_addr); end
    ack_with(32'hDDDD_CCCC);
    checks++; if (bif.instr !== 16'hDDDD) begin errors++; $display("FAIL branch_instr: got %h expected dddd", bif.instr); end
    checks++; if (bif.pc_read !== 32'h0000_020A) begin errors++; $display("FAIL branch_pc_read: got %h expected 0000020a", bif.pc_read); end
    $display("branch: pc=%h instr=%h", bif.pc, bif.instr);
  endtask

  task automatic test_fault();
    int cnt;
    do_ld(1'b1, 32'h0000_0500);
    cnt = 0;
    while (bif.imem_req === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
    checks++; if (cnt !== 15) begin errors++; $display("FAIL fault_req_cycles: got %0d expected 15", cnt); end
    checks++; if (bif.fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_flag: got %b expected 1", bif.fetch_fault); end
    checks++; if (bif.instr_valid !== 1'b0) begin errors++; $display("FAIL fault_valid: got %b expected 0", bif.instr_valid); end
    ack_with(32'h5555_5555);
    checks++; if (bif.fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_ack_ignored: got %b expected 1", bif.fetch_fault); end
    do_ld(1'b1, 32'h0000_0300);
    checks++; if (bif.fetch_fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b expected 0", bif.fetch_fault); end
    checks++; if (bif.imem_addr !== 32'h0000_0300) begin errors++; $display("FAIL fault_addr: got %h expected 00000300", bif.imem_addr); end
    checks++; if (bif.imem_req !== 1'b1) begin errors++; $display("FAIL fault_req: got %b expected 1", bif.imem_req); end
    ack_with(32'h5678_1234);
    checks++; if (bif.instr !== 16'h1234) begin errors++; $display("FAIL fault_recover_instr: got %h expected 1234", bif.instr); end
    $display("fault: req cycles=%0d, recovered pc=%h", cnt, bif.pc);
  endtask

  task automatic test_inflight();
    do_ld(1'b1, 32'h0000_0104);
    step();
    do_ld(1'b1, 32'h0000_0400);
    checks++; if (bif.imem_addr !== 32'h0000_0104) begin errors++; $display("FAIL inflight_addr: got %h expected 00000104", bif.imem_addr); end
    checks++; if (bif.pc !== 32'h0000_0400) begin errors++; $display("FAIL inflight_pc: got %h expected 00000400", bif.pc); end
    step();
    checks++; if (bif.imem_addr !== 32'h0000_0104) begin errors++; $display("FAIL inflight_addr_hold: got %h expected 00000104", bif.imem_addr); end
    ack_with(32'h2222_1111);
    checks++; if (bif.imem_req !== 1'b1) begin errors++; $display("FAIL inflight_rereq: got %b expected 1", bif.imem_req); end
    checks++; if (bif.imem_addr !== 32'h0000_0400) begin errors++; $display("FAIL inflight_newaddr: got %h expected 00000400", bif.imem_addr); end
    checks++; if (bif.instr_valid !== 1'b0) begin errors++; $display("FAIL inflight_valid: got %b expected 0", bif.instr_valid); end
    ack_with(32'h4444_4040);
    checks++; if (bif.instr !== 16'h4040) begin errors++; $display("FAIL inflight_instr: got %h expected 4040", bif.instr); end
    checks++; if (bif.instr_valid !== 1'b1) begin errors++; $display("FAIL inflight_valid2: got %b expected 1", bif.instr_valid); end
    $display("inflight: pc=%h instr=%h", bif.pc, bif.instr);
  endtask

  task automatic test_back_to_back();
    // ack and ld_pc together, next_pc inside the returned word
    do_ld(1'b1, 32'h0000_0204);
    bif.ld_pc = 1'b1;
    ack_with(32'hDDDD_CCCC);
    bif.ld_pc = 1'b0;
    checks++; if (bif.pc !== 32'h0000_0206) begin errors++; $display("FAIL b2b_hit_pc: got %h expected 00000206", bif.pc); end
    checks++; if (bif.instr !== 16'hDDDD) begin errors++; $display("FAIL b2b_hit_instr: got %h expected dddd", bif.instr); end
    checks++; if (bif.instr_valid !== 1'b1) begin errors++; $display("FAIL b2b_hit_valid: got %b expected 1", bif.instr_valid); end
    // ack and ld_pc together, next_pc outside the returned word
    do_ld(1'b1, 32'h0000_0104);
    bif.ld_pc = 1'b1; bif.cu_branch = 1'b1; bif.branch_target = 32'h0000_0100;
    ack_with(32'h2222_1111);
    bif.ld_pc = 1'b0; bif.cu_branch = 1'b0;
    checks++; if (bif.imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL b2b_miss_addr: got %h expected 00000100", bif.imem_addr); end
    checks++; if (bif.instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_miss_valid: got %b expected 0", bif.instr_valid); end
    ack_with(32'hBBBB_AAAA);
    checks++; if (bif.instr !== 16'hAAAA) begin errors++; $display("FAIL b2b_miss_instr: got %h expected aaaa", bif.instr); end
    $display("back to back: pc=%h instr=%h", bif.pc, bif.instr);
  endtask

  task automatic test_wrap();
    do_ld(1'b1, 32'hFFFF_FFFF);
    checks++; if (bif.pc !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_branch_pc: got %h expected fffffffe", bif.pc); end
    ack_with(32'h9999_8888);
    checks++; if (bif.instr !== 16'h9999) begin errors++; $display("FAIL wrap_instr: got %h expected 9999", bif.instr); end
    do_ld(1'b0, 32'd0);
    checks++; if (bif.pc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc: got %h expected 00000000", bif.pc); end
    checks++; if (bif.imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", bif.imem_addr); end
    ack_with(32'h7777_6666);
    $display("wrap: pc=%h instr=%h", bif.pc, bif.instr);
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    bif.ld_pc = 1'b1; bif.cu_branch = 1'b1; bif.branch_target = 32'h0000_0700;
    step();
    rst = 1'b0;
    bif.ld_pc = 1'b0; bif.cu_branch = 1'b0;
    checks++; if (bif.pc !== 32'h0000_0100) begin errors++; $display("FAIL rstprio_pc: got %h expected 00000100", bif.pc); end
    checks++; if (bif.imem_req !== 1'b1) begin errors++; $display("FAIL rstprio_req: got %b expected 1", bif.imem_req); end
    checks++; if (bif.instr !== 16'h0000) begin errors++; $display("FAIL rstprio_instr: got %h expected 0000", bif.instr); end
    $display("reset priority: pc=%h", bif.pc);
  endtask

  initial begin
    bif.ld_pc = 1'b0;
    bif.cu_branch = 1'b0;
    bif.branch_target = 32'd0;
    bif.imem_rdata = 32'd0;
    bif.imem_ack = 1'b0;
    step();
    test_reset();
    test_first_fetch();
    test_hit();
    test_miss();
    test_branch();
    test_fault();
    test_inflight();
    test_back_to_back();
    test_wrap();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
